// File: rtl/count_checker.sv
// Observer/checker for a free-running up-counter: predicts each value, tracks lock, counts errors and wraps.
// Optional macro COUNT_CHECKER_STICKY_EN adds err_clr input and err_sticky output.
module count_checker #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned LOCK_CYCLES = 4,
   parameter int unsigned ERR_W       = 8,
   parameter int unsigned WRAP_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  value,
   input  logic              cnt_enable,
   input  logic              cnt_reset,
`ifdef COUNT_CHECKER_STICKY_EN
   input  logic              err_clr,
   output logic              err_sticky,
`endif
   output logic              locked,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_count,
   output logic [WRAP_W-1:0] wrap_count,
   output logic [WIDTH-1:0]  last_value
);

   localparam int unsigned MC_W = 4;

   typedef enum logic [1:0] {
      SEED    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  last_q;
   logic              en_q;
   logic              rst_q;
   logic [MC_W-1:0]   match_cnt_q;
   logic              locked_q;
   logic              err_pulse_q;
   logic [ERR_W-1:0]  err_q;
   logic [WRAP_W-1:0] wrap_q;

   logic [WIDTH-1:0]  exp_c;
   logic              match_c;
   logic              wrap_c;
   logic              lock_hit_c;

   // Prediction of the current value from the previous edge's sample and controls
   always_comb begin
      exp_c      = last_q;
      if (rst_q) begin
         exp_c = '0;
      end else if (en_q) begin
         exp_c = last_q + WIDTH'(1);
      end
      match_c    = (value == exp_c);
      wrap_c     = match_c && (&last_q) && en_q && !rst_q && (value == '0);
      lock_hit_c = (match_cnt_q == MC_W'(LOCK_CYCLES - 1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SEED;
         last_q      <= '0;
         en_q        <= 1'b0;
         rst_q       <= 1'b0;
         match_cnt_q <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_q       <= '0;
         wrap_q      <= '0;
      end else begin
         last_q      <= value;
         en_q        <= cnt_enable;
         rst_q       <= cnt_reset;
         err_pulse_q <= 1'b0;
         locked_q    <= (state_q == LOCKED);
         case (state_q)
            SEED: begin
               state_q <= ACQUIRE;
            end
            ACQUIRE: begin
               if (match_c) begin
                  if (lock_hit_c) begin
                     state_q     <= LOCKED;
                     match_cnt_q <= '0;
                  end else begin
                     match_cnt_q <= match_cnt_q + MC_W'(1);
                  end
               end else begin
                  match_cnt_q <= '0;
               end
            end
            LOCKED: begin
               if (match_c) begin
                  if (wrap_c && !(&wrap_q)) begin
                     wrap_q <= wrap_q + WRAP_W'(1);
                  end
               end else begin
                  err_pulse_q <= 1'b1;
                  if (!(&err_q)) begin
                     err_q <= err_q + ERR_W'(1);
                  end
                  match_cnt_q <= '0;
                  state_q     <= ACQUIRE;
               end
            end
            default: begin
               state_q <= SEED;
            end
         endcase
      end
   end

`ifdef COUNT_CHECKER_STICKY_EN
   logic err_sticky_q;
   logic err_set_c;

   assign err_set_c = (state_q == LOCKED) && !match_c;

   // Set rises together with err_pulse and takes priority over clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_sticky_q <= 1'b0;
      end else if (err_set_c) begin
         err_sticky_q <= 1'b1;
      end else if (err_clr) begin
         err_sticky_q <= 1'b0;
      end
   end

   assign err_sticky = err_sticky_q;
`endif

   assign locked     = locked_q;
   assign err_pulse  = err_pulse_q;
   assign err_count  = err_q;
   assign wrap_count = wrap_q;
   assign last_value = last_q;

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker: a counter model drives stimulus, a reference model predicts outputs.
module tb_count_checker;
   localparam int W       = 8;
   localparam int LOCK    = 4;
   localparam int EW      = 8;
   localparam int WW      = 16;
   localparam int VMOD    = 1 << W;
   localparam int ERR_MAX = (1 << EW) - 1;
   localparam int WRP_MAX = (1 << WW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [W-1:0]  value = '0;
   logic          cnt_enable = 1'b0;
   logic          cnt_reset = 1'b0;
   logic          locked;
   logic          err_pulse;
   logic [EW-1:0] err_count;
   logic [WW-1:0] wrap_count;
   logic [W-1:0]  last_value;
`ifdef COUNT_CHECKER_STICKY_EN
   logic          err_clr = 1'b0;
   logic          err_sticky;
   bit            clr_drv = 1'b0;
`endif

   always #5 clk = ~clk;

   count_checker #(.WIDTH(W), .LOCK_CYCLES(LOCK), .ERR_W(EW), .WRAP_W(WW)) dut (
      .clk        (clk),
      .reset      (reset),
      .value      (value),
      .cnt_enable (cnt_enable),
      .cnt_reset  (cnt_reset),
`ifdef COUNT_CHECKER_STICKY_EN
      .err_clr    (err_clr),
      .err_sticky (err_sticky),
`endif
      .locked     (locked),
      .err_pulse  (err_pulse),
      .err_count  (err_count),
      .wrap_count (wrap_count),
      .last_value (last_value)
   );

   typedef struct {
      bit locked;
      bit pulse;
      int errs;
      int wraps;
      int last;
      bit sticky;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model, expressed as the rules of the checker rather than its register structure
   int m_last = 0;
   bit m_en = 0, m_rst = 0;
   bit m_seeded = 0, m_inlock = 0, m_lock_out = 0, m_sticky = 0;
   int m_streak = 0, m_errs = 0, m_wraps = 0;
   int ctr = 0;

   task automatic model_edge(input int v, input bit en, input bit r, input bit rn, input bit clr);
      exp_t e;
      int   pred;
      bit   pulse;
      pulse = 0;
      if (!rn) begin
         m_last = 0; m_en = 0; m_rst = 0; m_seeded = 0; m_inlock = 0; m_lock_out = 0;
         m_streak = 0; m_errs = 0; m_wraps = 0; m_sticky = 0;
      end else begin
         pred = m_rst ? 0 : (m_en ? (m_last + 1) % VMOD : m_last);
         m_lock_out = m_inlock;
         if (!m_seeded) begin
            m_seeded = 1;
         end else if (!m_inlock) begin
            if (v == pred) begin
               m_streak++;
               if (m_streak == LOCK) begin m_inlock = 1; m_streak = 0; end
            end else begin
               m_streak = 0;
            end
         end else if (v == pred) begin
            if (m_last == VMOD - 1 && m_en && !m_rst && v == 0 && m_wraps < WRP_MAX) m_wraps++;
         end else begin
            pulse = 1;
            if (m_errs < ERR_MAX) m_errs++;
            m_inlock = 0;
            m_streak = 0;
         end
         if (pulse) m_sticky = 1;
         else if (clr) m_sticky = 0;
         m_last = v; m_en = en; m_rst = r;
      end
      e.locked = m_lock_out; e.pulse = pulse; e.errs = m_errs; e.wraps = m_wraps;
      e.last = m_last; e.sticky = m_sticky;
      q.push_back(e);
   endtask

   task automatic step(input int v, input bit en, input bit r, input bit rn);
      bit clr;
      clr = 0;
      @(negedge clk);
      value = W'(v);
      cnt_enable = en;
      cnt_reset = r;
      reset = rn;
`ifdef COUNT_CHECKER_STICKY_EN
      err_clr = clr_drv;
      clr = clr_drv;
`endif
      model_edge(v, en, r, rn, clr);
   endtask

   // Drive the well-behaved counter for n cycles
   task automatic run_ctr(input int n, input bit en, input bit r);
      repeat (n) begin
         step(ctr, en, r, 1'b1);
         ctr = r ? 0 : (en ? (ctr + 1) % VMOD : ctr);
      end
   endtask

   task automatic do_reset(input int n);
      repeat (n) step(ctr, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic void chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
      end
   endfunction

   // Monitor: compares DUT outputs after each edge against the queued prediction
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("locked", int'(locked), int'(e.locked));
            chk("err_pulse", int'(err_pulse), int'(e.pulse));
            chk("err_count", int'(err_count), e.errs);
            chk("wrap_count", int'(wrap_count), e.wraps);
            chk("last_value", int'(last_value), e.last);
`ifdef COUNT_CHECKER_STICKY_EN
            chk("err_sticky", int'(err_sticky), int'(e.sticky));
`endif
         end
      end
   end

   initial begin
      bit en, r;
      do_reset(2);
      // Release with counter held in reset, then count through one wrap
      run_ctr(3, 1'b0, 1'b1);
      run_ctr(300, 1'b1, 1'b0);
      // Skip 0x10 -> 0x12
      while (ctr != 8'h10) run_ctr(1, 1'b1, 1'b0);
      run_ctr(1, 1'b1, 1'b0);
      ctr = 8'h12;
      run_ctr(10, 1'b1, 1'b0);
      // Reset and enable together at 0x37
      while (ctr != 8'h37) run_ctr(1, 1'b1, 1'b0);
      run_ctr(1, 1'b1, 1'b1);
      run_ctr(10, 1'b1, 1'b0);
      // Hold at 0x5A, then glitch to 0x5B
      while (ctr != 8'h5A) run_ctr(1, 1'b1, 1'b0);
      run_ctr(20, 1'b0, 1'b0);
      ctr = 8'h5B;
      run_ctr(10, 1'b0, 1'b0);
      // Repeated injected errors drive err_count into saturation
      repeat (300) begin
         ctr = (ctr + 1) % VMOD;
         run_ctr(6, 1'b0, 1'b0);
      end
      // Reset mid-operation, then randomized traffic with glitches
      do_reset(1);
      ctr = 0;
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset(2);
         en = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 49) == 0) ctr = $urandom_range(0, VMOD - 1);
`ifdef COUNT_CHECKER_STICKY_EN
         clr_drv = ($urandom_range(0, 7) == 0);
`endif
         run_ctr(1, en, r);
      end
`ifdef COUNT_CHECKER_STICKY_EN
      clr_drv = 0;
      run_ctr(8, 1'b1, 1'b0);
      ctr = (ctr + 5) % VMOD;
      run_ctr(2, 1'b1, 1'b0);
      clr_drv = 1;
      run_ctr(1, 1'b1, 1'b0);
      clr_drv = 0;
      run_ctr(8, 1'b1, 1'b0);
      clr_drv = 1;
      ctr = (ctr + 5) % VMOD;
      run_ctr(1, 1'b1, 1'b0);
      clr_drv = 0;
      run_ctr(4, 1'b1, 1'b0);
`endif
      run_ctr(4, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
